// File: rtl/traffic_monitor_if.sv
// Lamp, tick and fault-release signals observed by traffic_monitor, plus its status outputs.
// The master side drives the lamps; the slave side (the monitor) reports phase, dwell and faults.
interface traffic_monitor_if;
   logic       tick;
   logic [1:0] north;
   logic [1:0] east;
   logic [1:0] south;
   logic [1:0] west;
   logic       clear_fault;
   logic [3:0] phase;
   logic       tracking;
   logic       fault;
   logic [2:0] fault_code;
   logic [4:0] dwell;
   logic [7:0] cycle_count;

   modport master (
      output tick, north, east, south, west, clear_fault,
      input  phase, tracking, fault, fault_code, dwell, cycle_count
   );

   modport slave (
      input  tick, north, east, south, west, clear_fault,
      output phase, tracking, fault, fault_code, dwell, cycle_count
   );
endinterface

// File: rtl/traffic_monitor.sv
// Watches a four-way junction's lamps, follows the P0..P7 phase cycle and latches the first rule violation.
// Optional feature: define TRAFFIC_MON_CYCLE_COUNT_EN to count completed P7->P0 cycles.
module traffic_monitor #(
   parameter int GREEN_MIN  = 5,
   parameter int GREEN_MAX  = 6,
   parameter int YELLOW_MAX = 2
) (
   input  logic             clk,
   input  logic             reset,
   traffic_monitor_if.slave bus
);

   typedef enum logic [1:0] {
      LAMP_RED     = 2'b00,
      LAMP_YELLOW  = 2'b01,
      LAMP_GREEN   = 2'b10,
      LAMP_ILLEGAL = 2'b11
   } lamp_e;

   typedef struct packed {
      logic [1:0] north;
      logic [1:0] east;
      logic [1:0] south;
      logic [1:0] west;
   } lamps_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TRACK,
      ST_FAULT
   } state_e;

   typedef enum logic [2:0] {
      FC_NONE         = 3'd0,
      FC_ILLEGAL_LAMP = 3'd1,
      FC_MULTI_GREEN  = 3'd2,
      FC_UNKNOWN      = 3'd3,
      FC_BAD_SEQUENCE = 3'd4,
      FC_DWELL_LONG   = 3'd5,
      FC_DWELL_SHORT  = 3'd6
   } fault_e;

   localparam logic [3:0] PH_P0         = 4'd0;
   localparam logic [3:0] PH_P7         = 4'd7;
   localparam logic [3:0] PH_ALL_YELLOW = 4'd8;
   localparam logic [3:0] PH_UNKNOWN    = 4'd15;
   localparam logic [4:0] DWELL_SAT     = 5'd31;
   localparam logic [4:0] GREEN_MIN_D   = 5'(GREEN_MIN);
   localparam logic [4:0] GREEN_MAX_D   = 5'(GREEN_MAX);
   localparam logic [4:0] YELLOW_MAX_D  = 5'(YELLOW_MAX);
   localparam lamps_t     LAMPS_ALL_YELLOW = '{
      north: LAMP_YELLOW, east: LAMP_YELLOW, south: LAMP_YELLOW, west: LAMP_YELLOW
   };

   function automatic logic [3:0] decode_phase(input lamps_t l);
      logic [3:0] ph;
      case (l)
         {LAMP_GREEN,  LAMP_RED,    LAMP_RED,    LAMP_RED   }: ph = 4'd0;
         {LAMP_YELLOW, LAMP_YELLOW, LAMP_RED,    LAMP_RED   }: ph = 4'd1;
         {LAMP_RED,    LAMP_GREEN,  LAMP_RED,    LAMP_RED   }: ph = 4'd2;
         {LAMP_RED,    LAMP_YELLOW, LAMP_YELLOW, LAMP_RED   }: ph = 4'd3;
         {LAMP_RED,    LAMP_RED,    LAMP_GREEN,  LAMP_RED   }: ph = 4'd4;
         {LAMP_RED,    LAMP_RED,    LAMP_YELLOW, LAMP_YELLOW}: ph = 4'd5;
         {LAMP_RED,    LAMP_RED,    LAMP_RED,    LAMP_GREEN }: ph = 4'd6;
         {LAMP_YELLOW, LAMP_RED,    LAMP_RED,    LAMP_YELLOW}: ph = 4'd7;
         {LAMP_YELLOW, LAMP_YELLOW, LAMP_YELLOW, LAMP_YELLOW}: ph = PH_ALL_YELLOW;
         default:                                              ph = PH_UNKNOWN;
      endcase
      return ph;
   endfunction

   // Even numbered P-phases are the single-green phases, odd ones the yellow handovers.
   function automatic logic is_green_phase(input logic [3:0] ph);
      return !ph[3] && !ph[0];
   endfunction

   function automatic logic is_yellow_phase(input logic [3:0] ph);
      return !ph[3] && ph[0];
   endfunction

   lamps_t     lamps_in;
   lamps_t     samp_q;
   lamps_t     prev_q;
   logic       tick_q;
   state_e     state_q;
   state_e     state_d;
   logic [4:0] dwell_q;
   logic [4:0] dwell_d;
   fault_e     fault_code_q;
   fault_e     fault_code_d;
   fault_e     check_code;

   logic [3:0] samp_phase;
   logic [3:0] prev_phase;
   logic       change;
   logic       illegal_lane;
   logic [2:0] green_count;
   logic       multi_green;
   logic       seq_ok;
   logic       dwell_long;
   logic       dwell_short;
   logic [4:0] dwell_track;

   assign lamps_in = '{north: bus.north, east: bus.east, south: bus.south, west: bus.west};

   // Lamps and tick are registered together so a tick presented with a new pattern lands on the change cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         samp_q <= LAMPS_ALL_YELLOW;
         prev_q <= LAMPS_ALL_YELLOW;
         tick_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so prev_q captures the samp_q value from before this edge.
         samp_q <= lamps_in;
         prev_q <= samp_q;
         tick_q <= bus.tick;
      end
   end

   assign samp_phase = decode_phase(samp_q);
   assign prev_phase = decode_phase(prev_q);
   assign change     = (samp_q != prev_q);

   assign illegal_lane = (samp_q.north == LAMP_ILLEGAL) || (samp_q.east == LAMP_ILLEGAL) ||
                         (samp_q.south == LAMP_ILLEGAL) || (samp_q.west == LAMP_ILLEGAL);
   assign green_count  = 3'(samp_q.north == LAMP_GREEN) + 3'(samp_q.east == LAMP_GREEN) +
                         3'(samp_q.south == LAMP_GREEN) + 3'(samp_q.west == LAMP_GREEN);
   assign multi_green  = (green_count >= 3'd2);

   assign seq_ok = ((prev_phase == PH_ALL_YELLOW) && (samp_phase == PH_P0)) ||
                   (!prev_phase[3] && (samp_phase == {1'b0, prev_phase[2:0] + 3'd1}));

   // On a change cycle dwell_q still belongs to the outgoing pattern, so the long check waits a cycle.
   assign dwell_long  = !change &&
                        ((is_green_phase(samp_phase)  && (dwell_q > GREEN_MAX_D)) ||
                         (is_yellow_phase(samp_phase) && (dwell_q > YELLOW_MAX_D)));
   assign dwell_short = change && is_green_phase(prev_phase) && (dwell_q < GREEN_MIN_D);

   assign dwell_track = change                          ? 5'd0 :
                        (tick_q && (dwell_q != DWELL_SAT)) ? dwell_q + 5'd1 : dwell_q;

   // Ordered lowest code first so simultaneous violations report the smallest code.
   always_comb begin
      check_code = FC_NONE;
      if (illegal_lane) begin
         check_code = FC_ILLEGAL_LAMP;
      end else if (multi_green) begin
         check_code = FC_MULTI_GREEN;
      end else if (state_q == ST_TRACK) begin
         if (samp_phase == PH_UNKNOWN) begin
            check_code = FC_UNKNOWN;
         end else if (change && !seq_ok) begin
            check_code = FC_BAD_SEQUENCE;
         end else if (dwell_long) begin
            check_code = FC_DWELL_LONG;
         end else if (dwell_short) begin
            check_code = FC_DWELL_SHORT;
         end
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d      = state_q;
      dwell_d      = dwell_q;
      fault_code_d = fault_code_q;
      case (state_q)
         ST_IDLE: begin
            dwell_d = 5'd0;
            if (check_code != FC_NONE) begin
               state_d      = ST_FAULT;
               fault_code_d = check_code;
            end else if ((samp_phase == PH_ALL_YELLOW) || (samp_phase == PH_P0)) begin
               state_d = ST_TRACK;
            end
         end
         ST_TRACK: begin
            if (check_code != FC_NONE) begin
               state_d      = ST_FAULT;
               fault_code_d = check_code;
            end else begin
               dwell_d = dwell_track;
            end
         end
         ST_FAULT: begin
            if (bus.clear_fault) begin
               state_d      = ST_IDLE;
               fault_code_d = FC_NONE;
               dwell_d      = 5'd0;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            fault_code_d = FC_NONE;
            dwell_d      = 5'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         dwell_q      <= 5'd0;
         fault_code_q <= FC_NONE;
      end else begin
         state_q      <= state_d;
         dwell_q      <= dwell_d;
         fault_code_q <= fault_code_d;
      end
   end

`ifdef TRAFFIC_MON_CYCLE_COUNT_EN
   logic [7:0] cycle_count_q;
   logic       cycle_done;

   assign cycle_done = (state_q == ST_TRACK) && (check_code == FC_NONE) && change &&
                       (prev_phase == PH_P7) && (samp_phase == PH_P0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_count_q <= 8'd0;
      end else if (cycle_done) begin
         cycle_count_q <= cycle_count_q + 8'd1;
      end
   end

   assign bus.cycle_count = cycle_count_q;
`else
   assign bus.cycle_count = 8'd0;
`endif

   assign bus.phase      = samp_phase;
   assign bus.tracking   = (state_q == ST_TRACK);
   assign bus.fault      = (state_q == ST_FAULT);
   assign bus.fault_code = fault_code_q;
   assign bus.dwell      = dwell_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed bench for traffic_monitor: expected outputs are queued when a step is driven
// and compared two edges later, when the monitor's registered outputs reflect that step.
module tb_traffic_monitor;

   localparam logic [7:0] AY  = 8'h55;
   localparam logic [7:0] P0  = 8'h80;
   localparam logic [7:0] P1  = 8'h50;
   localparam logic [7:0] P2  = 8'h20;
   localparam logic [7:0] P3  = 8'h14;
   localparam logic [7:0] P4  = 8'h08;
   localparam logic [7:0] P5  = 8'h05;
   localparam logic [7:0] P6  = 8'h02;
   localparam logic [7:0] P7  = 8'h41;
   localparam logic [7:0] NE_GREEN   = 8'hA0;
   localparam logic [7:0] P3_W_ILL   = 8'h17;
   localparam logic [7:0] ALL_ILL    = 8'hFF;

`ifdef TRAFFIC_MON_CYCLE_COUNT_EN
   localparam logic [7:0] CC_AFTER_RUN = 8'd1;
`else
   localparam logic [7:0] CC_AFTER_RUN = 8'd0;
`endif

   typedef struct {
      string      tag;
      int         due;
      logic [3:0] phase;
      logic       tracking;
      logic       fault;
      logic [2:0] code;
      logic [4:0] dwell;
      logic [7:0] cc;
   } exp_t;

   logic       clk;
   logic       reset;
   int         cyc;
   int         checks;
   int         errors;
   logic [7:0] cur_lamps;
   logic [7:0] exp_cc;
   exp_t       sb[$];

   traffic_monitor_if bus ();

   traffic_monitor dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input string field, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s %s: observed=%0h expected=%0h", tag, field, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check(tag, "phase",       8'(bus.phase),      8'd8);
      check(tag, "tracking",    8'(bus.tracking),   8'd0);
      check(tag, "fault",       8'(bus.fault),      8'd0);
      check(tag, "fault_code",  8'(bus.fault_code), 8'd0);
      check(tag, "dwell",       8'(bus.dwell),      8'd0);
      check(tag, "cycle_count", bus.cycle_count,    8'd0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         check(e.tag, "phase",       8'(bus.phase),      8'(e.phase));
         check(e.tag, "tracking",    8'(bus.tracking),   8'(e.tracking));
         check(e.tag, "fault",       8'(bus.fault),      8'(e.fault));
         check(e.tag, "fault_code",  8'(bus.fault_code), 8'(e.code));
         check(e.tag, "dwell",       8'(bus.dwell),      8'(e.dwell));
         check(e.tag, "cycle_count", bus.cycle_count,    e.cc);
      end
   end

   task automatic drive(input logic [7:0] l, input logic tk, input logic clr);
      @(negedge clk);
      bus.north       = l[7:6];
      bus.east        = l[5:4];
      bus.south       = l[3:2];
      bus.west        = l[1:0];
      bus.tick        = tk;
      bus.clear_fault = clr;
      cur_lamps       = l;
   endtask

   task automatic expect_out(input string tag, input int lat, input logic [3:0] ph, input logic trk,
                             input logic flt, input logic [2:0] code, input logic [4:0] dw);
      exp_t e;
      e.tag      = tag;
      e.due      = cyc + lat;
      e.phase    = ph;
      e.tracking = trk;
      e.fault    = flt;
      e.code     = code;
      e.dwell    = dw;
      e.cc       = exp_cc;
      sb.push_back(e);
   endtask

   // Expect the state two edges after the last driven step, holding the pattern with no tick meanwhile.
   task automatic settle(input string tag, input logic [3:0] ph, input logic trk,
                         input logic flt, input logic [2:0] code, input logic [4:0] dw);
      expect_out(tag, 2, ph, trk, flt, code, dw);
      drive(cur_lamps, 1'b0, 1'b0);
      drive(cur_lamps, 1'b0, 1'b0);
   endtask

   task automatic hold(input logic [7:0] l, input int n_ticks);
      drive(l, 1'b0, 1'b0);
      repeat (n_ticks) begin
         drive(l, 1'b1, 1'b0);
         drive(l, 1'b0, 1'b0);
      end
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      exp_cc          = 8'd0;
      reset           = 1'b1;
      cur_lamps       = AY;
      bus.north       = AY[7:6];
      bus.east        = AY[5:4];
      bus.south       = AY[3:2];
      bus.west        = AY[1:0];
      bus.tick        = 1'b0;
      bus.clear_fault = 1'b0;
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      reset = 1'b1;
      settle("after_reset", 4'd8, 1'b1, 1'b0, 3'd0, 5'd0);

      hold(P0, 5);
      settle("p0_dwell", 4'd0, 1'b1, 1'b0, 3'd0, 5'd5);
      hold(P1, 1);
      hold(P2, 5);
      hold(P3, 1);
      hold(P4, 5);
      hold(P5, 1);
      hold(P6, 5);
      hold(P7, 1);
      drive(P0, 1'b0, 1'b0);
      exp_cc = CC_AFTER_RUN;
      settle("legal_run", 4'd0, 1'b1, 1'b0, 3'd0, 5'd0);

      drive(NE_GREEN, 1'b0, 1'b0);
      expect_out("two_green_edge1", 1, 4'd15, 1'b1, 1'b0, 3'd0, 5'd0);
      settle("two_green", 4'd15, 1'b0, 1'b1, 3'd2, 5'd0);

      drive(AY, 1'b0, 1'b1);
      expect_out("clear_edge1", 1, 4'd8, 1'b0, 1'b0, 3'd0, 5'd0);
      settle("clear_to_track", 4'd8, 1'b1, 1'b0, 3'd0, 5'd0);

      hold(P0, 6);
      settle("p0_six", 4'd0, 1'b1, 1'b0, 3'd0, 5'd6);
      drive(P0, 1'b1, 1'b0);
      drive(P0, 1'b0, 1'b0);
      expect_out("dwell_long_edge1", 1, 4'd0, 1'b1, 1'b0, 3'd0, 5'd7);
      settle("dwell_long", 4'd0, 1'b0, 1'b1, 3'd5, 5'd7);

      drive(ALL_ILL, 1'b1, 1'b0);
      settle("fault_hold", 4'd15, 1'b0, 1'b1, 3'd5, 5'd7);

      drive(P3, 1'b0, 1'b1);
      settle("clear_idle_p3", 4'd3, 1'b0, 1'b0, 3'd0, 5'd0);
      settle("idle_hold_p3", 4'd3, 1'b0, 1'b0, 3'd0, 5'd0);

      drive(P3_W_ILL, 1'b0, 1'b0);
      settle("idle_illegal", 4'd15, 1'b0, 1'b1, 3'd1, 5'd0);
      drive(AY, 1'b0, 1'b1);
      settle("recover_a", 4'd8, 1'b1, 1'b0, 3'd0, 5'd0);

      hold(P0, 3);
      drive(P1, 1'b0, 1'b0);
      settle("dwell_short", 4'd1, 1'b0, 1'b1, 3'd6, 5'd3);
      drive(AY, 1'b0, 1'b1);
      settle("recover_b", 4'd8, 1'b1, 1'b0, 3'd0, 5'd0);

      hold(P0, 5);
      hold(P1, 1);
      hold(P2, 5);
      drive(P2, 1'b0, 1'b1);
      settle("clear_in_track", 4'd2, 1'b1, 1'b0, 3'd0, 5'd5);
      drive(P4, 1'b0, 1'b0);
      settle("bad_seq", 4'd4, 1'b0, 1'b1, 3'd4, 5'd5);
      drive(AY, 1'b0, 1'b1);
      settle("recover_c", 4'd8, 1'b1, 1'b0, 3'd0, 5'd0);

      hold(P0, 5);
      drive(P1, 1'b1, 1'b0);
      settle("tick_on_change", 4'd1, 1'b1, 1'b0, 3'd0, 5'd0);
      hold(P1, 2);
      settle("p1_two", 4'd1, 1'b1, 1'b0, 3'd0, 5'd2);
      drive(P1, 1'b1, 1'b0);
      drive(P1, 1'b0, 1'b0);
      settle("yellow_long", 4'd1, 1'b0, 1'b1, 3'd5, 5'd3);

      #2 reset = 1'b0;
      exp_cc = 8'd0;
      #1 check_reset_values("reset_in_fault");
      drive(AY, 1'b0, 1'b0);
      reset = 1'b1;
      hold(AY, 8);
      settle("ay_untimed", 4'd8, 1'b1, 1'b0, 3'd0, 5'd8);

      repeat (3) drive(cur_lamps, 1'b0, 1'b0);
      check("scoreboard_drain", "pending", 8'(sb.size()), 8'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/traffic_monitor.md
TRAFFIC_MONITOR -- requirements
Module: traffic_monitor

Interface
REQ-001 Parameter GREEN_MIN, default 5, minimum legal green dwell in ticks.
REQ-002 Parameter GREEN_MAX, default 6, maximum legal green dwell in ticks.
REQ-003 Parameter YELLOW_MAX, default 2, maximum legal yellow dwell in ticks.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 tick  input  1  one-cycle pulse, one per second.
REQ-007 north, east, south, west  input  2 each  lamp codes: 00 red, 01 yellow, 10 green, 11 illegal.
REQ-008 clear_fault  input  1  single-cycle request to release a latched fault.
REQ-009 phase  output  4  decoded phase: 0-7 = P0-P7, 8 = ALL_YELLOW, 15 = unknown.
REQ-010 tracking  output  1  high while the FSM is in TRACK.
REQ-011 fault  output  1  latched fault flag.
REQ-012 fault_code  output  3  cause of the latched fault; 0 when no fault.
REQ-013 dwell  output  5  ticks spent in the current pattern, saturating at 31.
REQ-014 cycle_count  output  8  completed P7->P0 transitions (see Configuration).

Function
REQ-015 Inputs SHALL be sampled into a register samp each cycle; prev SHALL hold samp from the previous cycle; change = (samp != prev).
REQ-016 Decode from samp: P0 N=G; P1 N=Y,E=Y; P2 E=G; P3 E=Y,S=Y; P4 S=G; P5 S=Y,W=Y; P6 W=G; P7 N=Y,W=Y; ALL_YELLOW all Y; every unlisted lane SHALL be red, otherwise unknown.
REQ-017 The FSM SHALL have three states: IDLE, TRACK, FAULT.
REQ-018 IDLE -> TRACK when the samp phase is ALL_YELLOW or P0; any other pattern SHALL hold IDLE with no sequence fault.
REQ-019 In TRACK, on change, the only legal successors SHALL be ALL_YELLOW->P0 and Pn->P(n+1 mod 8); anything else SHALL raise code 4 (BAD_SEQUENCE).
REQ-020 Codes 1 (any lane 11) and 2 (two or more greens) SHALL be checked in IDLE and TRACK; codes 3-6 SHALL be checked in TRACK only.
REQ-021 Code 3 (UNKNOWN) SHALL be raised when the samp phase decodes to 15.
REQ-022 Code 5 (DWELL_LONG) SHALL be raised when dwell exceeds GREEN_MAX in P0/P2/P4/P6, or exceeds YELLOW_MAX in P1/P3/P5/P7; ALL_YELLOW SHALL be untimed.
REQ-023 Code 6 (DWELL_SHORT) SHALL be raised on a change out of a green phase with dwell < GREEN_MIN.
REQ-024 When several codes are raised together, the lowest code number SHALL be latched.
REQ-025 On any fault: enter FAULT, set fault=1 and load fault_code on the same edge; the fault SHALL be visible two rising edges after the offending input is presented.
REQ-026 In FAULT, outputs SHALL hold and new faults SHALL be ignored; clear_fault SHALL move to IDLE, with fault=0 and fault_code=0 on the next edge.
REQ-027 clear_fault SHALL have no effect outside FAULT.
REQ-028 dwell SHALL clear to 0 on change; it SHALL otherwise increment on tick and saturate at 31.
REQ-029 If change and tick occur in the same cycle, dwell SHALL become 0.
REQ-030 dwell SHALL be held at 0 in IDLE.
REQ-031 phase SHALL reflect samp in all states.

Reset
REQ-032 While reset is low: state=IDLE, samp=prev=all-yellow, phase=8, tracking=0, fault=0, fault_code=0, dwell=0, cycle_count=0.
REQ-033 Reset asserted mid-operation SHALL abandon the current state immediately, including FAULT.

Configuration
REQ-034 Macro TRAFFIC_MON_CYCLE_COUNT_EN: when defined, cycle_count SHALL increment on each legal P7->P0 transition in TRACK and wrap 255->0.
REQ-035 When TRAFFIC_MON_CYCLE_COUNT_EN is undefined, cycle_count SHALL be constant 0 and the counter logic SHALL be absent.

Verification
REQ-036 Legal run: ALL_YELLOW, then P0 for 5 ticks, P1 for 1 tick, ... through P7 and back to P0 -> tracking=1, fault=0, cycle_count=1 (macro on) or 0 (macro off).
REQ-037 In TRACK, north=10 and east=10 together -> fault=1, fault_code=2, on the second edge after the inputs are applied.
REQ-038 In TRACK, P0 held for 7 ticks -> fault_code=5 once dwell reaches 7; a later clear_fault -> fault=0, state IDLE.
REQ-039 P0 changes to P1 after 3 ticks -> fault_code=6; P2 to P4 directly -> fault_code=4.
REQ-040 In IDLE, west=11 -> fault_code=1; in IDLE, pattern P3 -> tracking stays 0 and no fault.
REQ-041 reset asserted while in FAULT with fault_code=5 -> all outputs at their reset values asynchronously; tick coinciding with a change -> dwell=0.
